// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies,
// FSM state type and small op-class helpers. The control and hazard
// decoders import this package as well, so encodings live in one place.
// DIV/DIVU are only implemented when the MDU_DIV_EN macro is defined.
package mdu_pkg;

    // Width of the latency down-counter (must hold DIV_LATENCY)
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_LATENCY = 4'd5;
    localparam logic [CNT_W-1:0] DIV_LATENCY  = 4'd10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider working on magnitudes with a
// restoring-division array, then fixing signs: quotient truncates toward
// zero, remainder takes the dividend's sign. Flags a zero divisor so the
// caller can suppress the commit. Instantiated only under MDU_DIV_EN.
module mdu_divider
    import mdu_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        neg_a;
    logic        neg_b;
    logic        overflow;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_bits;
    logic [31:0] q_signed;
    logic [31:0] rem_stage [0:32];

    assign neg_a = is_signed & dividend[31];
    assign neg_b = is_signed & divisor[31];

    // 0x80000000 negates to itself, which is already its correct unsigned magnitude
    assign mag_a = neg_a ? (32'd0 - dividend) : dividend;
    assign mag_b = neg_b ? (32'd0 - divisor)  : divisor;

    assign rem_stage[0] = '0;

    // One restoring step per dividend bit, MSB first
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_stage
            logic [32:0] shifted;
            logic [32:0] diff;
            assign shifted = {rem_stage[gi], mag_a[31-gi]};
            assign diff    = shifted - {1'b0, mag_b};
            // No borrow out means the partial remainder covers the divisor
            assign q_bits[31-gi]   = ~diff[32];
            assign rem_stage[gi+1] = q_bits[31-gi] ? diff[31:0] : shifted[31:0];
        end
    endgenerate

    assign q_signed    = (neg_a ^ neg_b) ? (32'd0 - q_bits) : q_bits;
    assign div_by_zero = (divisor == 32'd0);

    // Most-negative / -1 cannot be represented; pin it to the wrapped value
    assign overflow = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    assign quotient  = overflow ? 32'h8000_0000 : q_signed;
    assign remainder = overflow ? 32'd0 : (neg_a ? (32'd0 - rem_stage[32]) : rem_stage[32]);

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. Operands are captured when a request is
// accepted; a down-counter models the fixed latency and HI/LO commit on the
// edge it expires. MTHI/MTLO write immediately. Divide support (DIV/DIVU)
// is built only when the MDU_DIV_EN macro is defined; otherwise those ops
// are no-ops.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [2:0]       op_reg, op_next;

    logic             idle;
    logic             accept_mult;
    logic             accept_div;
    logic             ext_a;
    logic             ext_b;
    logic [63:0]      product;

    assign idle        = (state_reg == ST_IDLE);
    assign accept_mult = start && idle && is_mult_op(op);

    // Sign-extend only for MULT; a 64x64 multiply truncated to 64 bits is exact
    assign ext_a   = (op_reg == OP_MULT) & a_reg[31];
    assign ext_b   = (op_reg == OP_MULT) & b_reg[31];
    assign product = {{32{ext_a}}, a_reg} * {{32{ext_b}}, b_reg};

`ifdef MDU_DIV_EN
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    assign accept_div = start && idle && is_div_op(op);

    mdu_divider u_divider (
        .dividend    (a_reg),
        .divisor     (b_reg),
        .is_signed   (op_reg == OP_DIV),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );
`else
    assign accept_div = 1'b0;
`endif

    // Next-state, latency counter and HI/LO update logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept_mult || accept_div) begin
                    state_next = ST_RUN;
                    cnt_next   = accept_mult ? MULT_LATENCY : DIV_LATENCY;
                    a_next     = src_a;
                    b_next     = src_b;
                    op_next    = op;
                end else if (start && (op == OP_MTHI)) begin
                    hi_next = src_a;
                end else if (start && (op == OP_MTLO)) begin
                    lo_next = src_a;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (is_mult_op(op_reg)) begin
                        hi_next = product[63:32];
                        lo_next = product[31:0];
                    end
`ifdef MDU_DIV_EN
                    else if (!div_by_zero) begin
                        hi_next = remainder;
                        lo_next = quotient;
                    end
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset discards any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit. Divide expectations depend on whether
// MDU_DIV_EN is defined for the build.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag, input logic b);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    // Present one request for a single edge, then scramble the inputs
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Expect busy for n cycles with HI/LO held, then idle
    task automatic wait_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk_state(tag, 1'b1);
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        src_a  = '0;
        src_b  = '0;
        exp_hi = '0;
        exp_lo = '0;

        repeat (2) @(negedge clk);
        chk_state("reset", 1'b0);
        $display("txn reset: busy=%0b hi=%h lo=%h", busy, hi, lo);

        // Release reset and request MTLO on the very first edge
        reset = 1'b1;
        issue(3'd5, 32'h1234_5678, 32'h0);
        exp_lo = 32'h1234_5678;
        chk_state("mtlo", 1'b0);
        $display("txn mtlo: busy=%0b hi=%h lo=%h", busy, hi, lo);

        issue(3'd4, 32'hCAFE_BABE, 32'h0);
        exp_hi = 32'hCAFE_BABE;
        chk_state("mthi", 1'b0);
        $display("txn mthi: busy=%0b hi=%h lo=%h", busy, hi, lo);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_busy("mult", 5);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFA;
        chk_state("mult_res", 1'b0);
        $display("txn mult: hi=%h lo=%h", hi, lo);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_busy("multu", 5);
        exp_hi = 32'h0000_0001;
        exp_lo = 32'hFFFF_FFFE;
        chk_state("multu_res", 1'b0);
        $display("txn multu: hi=%h lo=%h", hi, lo);

`ifdef MDU_DIV_EN
        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_busy("div", 10);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;
        chk_state("div_res", 1'b0);
        $display("txn div: hi=%h lo=%h", hi, lo);

        // DIVU 7 / 0 runs the full latency and commits nothing
        issue(3'd3, 32'd7, 32'd0);
        wait_busy("divu0", 10);
        chk_state("divu0_res", 1'b0);
        $display("txn divu0: hi=%h lo=%h", hi, lo);

        // Signed overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divovf", 10);
        exp_hi = 32'h0;
        exp_lo = 32'h8000_0000;
        chk_state("divovf_res", 1'b0);
        $display("txn divovf: hi=%h lo=%h", hi, lo);

        // DIVU 0xFFFFFFFF / 16
        issue(3'd3, 32'hFFFF_FFFF, 32'd16);
        wait_busy("divu", 10);
        exp_hi = 32'h0000_000F;
        exp_lo = 32'h0FFF_FFFF;
        chk_state("divu_res", 1'b0);
        $display("txn divu: hi=%h lo=%h", hi, lo);
`else
        // Without the divider DIV/DIVU behave as no-ops
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk_state("div_nop", 1'b0);
        @(negedge clk);
        chk_state("div_nop2", 1'b0);
        $display("txn div(disabled): busy=%0b hi=%h lo=%h", busy, hi, lo);
        issue(3'd3, 32'd7, 32'd1);
        chk_state("divu_nop", 1'b0);
        $display("txn divu(disabled): busy=%0b hi=%h lo=%h", busy, hi, lo);
`endif

        // Ops 6 and 7
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        chk_state("op6", 1'b0);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        chk_state("op7", 1'b0);
        $display("txn op6/op7: busy=%0b hi=%h lo=%h", busy, hi, lo);

        // MULT 3*4 with a second MULT and an MTLO attempted while busy
        issue(3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk_state("ign", 1'b1);
            if (i == 1) begin
                start = 1'b1; op = 3'd0; src_a = 32'd100; src_b = 32'd100;
            end else if (i == 3) begin
                start = 1'b1; op = 3'd5; src_a = 32'hDEAD_BEEF; src_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0000_000C;
        chk_state("ign_res", 1'b0);
        @(negedge clk);
        chk_state("ign_after", 1'b0);
        $display("txn mult_ignore: hi=%h lo=%h", hi, lo);

        // Reset during cycle 3 of a long operation
`ifdef MDU_DIV_EN
        issue(3'd2, 32'd100, 32'd7);
`else
        issue(3'd0, 32'd100, 32'd7);
`endif
        @(negedge clk);
        @(negedge clk);
        chk({"abort_pre_busy"}, {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        chk_state("abort", 1'b0);
        $display("txn abort: busy=%0b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_state("abort_after", 1'b0);
        end
        $display("txn abort_after: busy=%0b hi=%h lo=%h", busy, hi, lo);

        issue(3'd4, 32'h0BAD_F00D, 32'h0);
        exp_hi = 32'h0BAD_F00D;
        chk_state("mthi2", 1'b0);
        $display("txn mthi2: hi=%h lo=%h", hi, lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (low = reset asserted).
REQ-003 SHALL have port start, input, 1 bit: E-stage request to begin the operation selected by op.
REQ-004 SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-005 SHALL have port src_a, input, 32 bits: forwarded rs value (multiplicand or dividend; MTHI/MTLO data).
REQ-006 SHALL have port src_b, input, 32 bits: forwarded rt value (multiplier or divisor).
REQ-007 SHALL have port busy, output, 1 bit: operation in flight; the hazard unit stalls MFHI/MFLO/mult/div in D while start|busy.
REQ-008 SHALL have port hi, output, 32 bits: HI register, read by MFHI.
REQ-009 SHALL have port lo, output, 32 bits: LO register, read by MFLO.

Function
REQ-010 SHALL accept start only when busy=0 at the rising edge; start while busy=1 is ignored with no state change.
REQ-011 SHALL, on an accepted MULT/MULTU, assert busy from the next edge for exactly 5 cycles, then commit {hi,lo}=64-bit product.
REQ-012 SHALL, on an accepted DIV/DIVU, assert busy for exactly 10 cycles, then commit lo=quotient and hi=remainder.
REQ-013 SHALL capture src_a, src_b and op at the accepting edge; input changes during busy SHALL NOT affect the result.
REQ-014 SHALL implement latency with a down-counter loaded with 5 or 10; at the edge where it reaches 0, SHALL clear busy and update hi/lo on that same edge.
REQ-015 SHALL keep hi/lo at their previous values throughout busy.
REQ-016 SHALL produce signed results (MULT, DIV) in two's complement and unsigned results (MULTU, DIVU) as zero-extended values.
REQ-017 SHALL truncate signed quotients toward zero and give the remainder the dividend's sign.
REQ-018 SHALL, for divisor 0, still run busy for 10 cycles and leave hi/lo unchanged.
REQ-019 SHALL, for signed 0x80000000 / 0xFFFFFFFF, commit lo=0x80000000 and hi=0.
REQ-020 SHALL, on an accepted MTHI/MTLO, write src_a to hi/lo at that same edge without asserting busy.
REQ-021 SHALL treat ops 6 and 7 as no-ops: busy stays 0 and hi/lo are unchanged.
REQ-022 SHALL use a two-state FSM: IDLE goes to RUN on accepted MULT*/DIV*; RUN goes to IDLE when the counter expires.

Reset
REQ-023 SHALL, while reset is low, force busy=0, hi=0, lo=0, counter=0 and the FSM to IDLE, asynchronously.
REQ-024 SHALL discard any in-flight operation on reset, with no commit after reset deasserts.
REQ-025 SHALL accept a start on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, when macro MDU_DIV_EN is defined, implement DIV/DIVU as specified above.
REQ-027 SHALL, when MDU_DIV_EN is undefined, omit all divider logic, treat DIV/DIVU as no-ops (busy=0, hi/lo unchanged), and leave multiply and MTHI/MTLO unaffected.

Structure
REQ-028 SHALL place op encodings, MULT_LATENCY=5 and DIV_LATENCY=10 in shared package mdu_pkg, which the control and hazard decoders also use.
REQ-029 SHALL place the signed/unsigned quotient and remainder computation, including the zero-divisor and overflow rules, in sub-module mdu_divider, instantiated only under MDU_DIV_EN.

Verification
REQ-030 SHALL test: MULT with src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 SHALL test: MULTU with src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-032 SHALL test: DIV with src_a=-7, src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged.
REQ-033 SHALL test: second MULT start asserted during busy with different operands -> ignored; first result commits at cycle 5, busy then 0.
REQ-034 SHALL test: reset pulled low at cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately, with no later commit.
REQ-035 SHALL test: MTLO with src_a=0x12345678 while idle -> lo=0x12345678 the next cycle, busy never asserted.
